// File: rtl/vram_pkg.sv
// Shared types and defaults for the video RAM write-port scheduler.
package vram_pkg;

  localparam int   VRAM_ADDR_W    = 16;
  localparam logic VRAM_CLEAR_VAL = 1'b0;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational one-hot grant plus the pointer value
// the caller should register for the next cycle.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant,
  output logic       last_next
);

  always_comb begin
    grant     = 2'b00;
    last_next = last;
    // A lone requester always wins; on a tie the one not served most recently wins.
    grant[0]  = en & valid0 & (~valid1 | last);
    grant[1]  = en & valid1 & (~valid0 | ~last);
    if (grant[1]) begin
      last_next = 1'b1;
    end else if (grant[0]) begin
      last_next = 1'b0;
    end
  end

endmodule

// File: rtl/vram_write_sched.sv
// Write-port scheduler for the 1-bit video RAM: round-robin between two pixel
// writers, a full-screen clear sweep, and a freeze input that stalls all writes.
module vram_write_sched
  import vram_pkg::*;
#(
  parameter int   ADDR_W    = VRAM_ADDR_W,
  parameter logic CLEAR_VAL = VRAM_CLEAR_VAL
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_freeze,
  input  logic              i_clear,
  output logic              o_clear_busy,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic              i_req0_dat,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic              i_req1_dat,
  output logic              o_req1_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_dat
);

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              last_reg;
  logic              last_next;
  logic [1:0]        grant;
  logic              arb_en;

  // Gating with i_rst_n keeps both readies low while reset is held.
  assign arb_en = i_rst_n & (state_reg == ST_ARB) & ~i_clear & ~i_freeze;

  rr_arb2 u_arb (
    .valid0    (i_req0_valid),
    .valid1    (i_req1_valid),
    .last      (last_reg),
    .en        (arb_en),
    .grant     (grant),
    .last_next (last_next)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_ARB;
      cnt_reg      <= '0;
      last_reg     <= 1'b1;
      o_we         <= 1'b0;
      o_addr       <= '0;
      o_dat        <= 1'b0;
      o_clear_busy <= 1'b0;
    end else begin
      case (state_reg)
        ST_ARB: begin
          o_we     <= 1'b0;
          last_reg <= last_next;
          if (i_clear) begin
            state_reg    <= ST_CLEAR;
            cnt_reg      <= '0;
            o_clear_busy <= 1'b1;
          end else if (grant[0]) begin
            o_we   <= 1'b1;
            o_addr <= i_req0_addr;
            o_dat  <= i_req0_dat;
          end else if (grant[1]) begin
            o_we   <= 1'b1;
            o_addr <= i_req1_addr;
            o_dat  <= i_req1_dat;
          end
        end
        ST_CLEAR: begin
          if (i_freeze) begin
            o_we <= 1'b0;
          end else begin
            o_we    <= 1'b1;
            o_addr  <= cnt_reg;
            o_dat   <= CLEAR_VAL;
            cnt_reg <= cnt_reg + ADDR_W'(1);
            // Terminal on all-ones so the last address is still written.
            if (&cnt_reg) begin
              state_reg    <= ST_ARB;
              o_clear_busy <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= ST_ARB;
          o_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_sched.sv
// Directed bench: a 16-bit instance for arbitration vectors and a 4-bit
// instance for the clear sweep, freeze and mid-sweep reset sequences.
module tb_vram_write_sched;

  localparam logic I = 1'b1;
  localparam logic O = 1'b0;
  localparam int   NV = 21;

  logic        clk;
  logic        rst_n, freeze, clear;
  logic        v0, d0, v1, d1;
  logic [15:0] a0, a1;

  logic        busy16, r0_16, r1_16, we16, dat16;
  logic [15:0] addr16;
  logic        busy4, r0_4, r1_4, we4, dat4;
  logic [3:0]  addr4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_n, frz, clr, v0;
    logic [15:0] a0;
    logic        d0, v1;
    logic [15:0] a1;
    logic        d1, r0, r1, we;
    logic [15:0] addr;
    logic        dat;
  } vec_t;

  vec_t vecs[NV];

  vram_write_sched dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze), .i_clear(clear),
    .o_clear_busy(busy16),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_dat(d0), .o_req0_ready(r0_16),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_dat(d1), .o_req1_ready(r1_16),
    .o_we(we16), .o_addr(addr16), .o_dat(dat16)
  );

  vram_write_sched #(.ADDR_W(4), .CLEAR_VAL(1'b0)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze), .i_clear(clear),
    .o_clear_busy(busy4),
    .i_req0_valid(v0), .i_req0_addr(a0[3:0]), .i_req0_dat(d0), .o_req0_ready(r0_4),
    .i_req1_valid(v1), .i_req1_addr(a1[3:0]), .i_req1_dat(d1), .o_req1_ready(r1_4),
    .o_we(we4), .o_addr(addr4), .o_dat(dat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clear sweep on the 4-bit instance; freeze is high for loop cycles
  // [fa, fa+fl), where cycle -1 is the one in which clear is first sampled.
  task automatic sweep(input int fa, input int fl, input int exp_len);
    int nexp = 0;
    int busy_cnt = 0;
    logic froze;
    v0 = 1'b1; v1 = 1'b1;
    for (int c = -1; c < 60; c++) begin
      freeze = (c >= fa) && (c < fa + fl);
      clear  = (c < 2);
      if (c >= 0 && !busy4) break;
      if (c >= 0) busy_cnt++;
      #1;
      chk("sweep_ready0", 32'(r0_4), 32'd0);
      chk("sweep_ready1", 32'(r1_4), 32'd0);
      froze = freeze;
      @(posedge clk); #1;
      if (c >= 0 && !froze) begin
        chk("sweep_we", 32'(we4), 32'd1);
        chk("sweep_addr", 32'(addr4), 32'(nexp));
        chk("sweep_dat", 32'(dat4), 32'd0);
        nexp++;
      end else begin
        chk("sweep_we_idle", 32'(we4), 32'd0);
      end
    end
    freeze = 1'b0; clear = 1'b0;
    #1;
    chk("sweep_len", 32'(busy_cnt), 32'(exp_len));
    chk("sweep_writes", 32'(nexp), 32'd16);
    chk("grant_after_sweep", 32'(r0_4), 32'd1);
    $display("sweep freeze_at=%0d len=%0d busy_cycles=%0d writes=%0d", fa, fl, busy_cnt, nexp);
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    logic found;
    rst_n = 1'b0; freeze = 1'b0; clear = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 1'b0; d1 = 1'b0; a0 = '0; a1 = '0;

    //          rst frz clr v0  a0        d0 v1  a1        d1  r0 r1 we  addr      dat
    vecs[0]  = '{O, O, O, I, 16'h0000, O, I, 16'h0000, O,  O, O, O, 16'h0000, O};
    vecs[1]  = '{I, O, O, I, 16'h1234, I, O, 16'h0000, O,  I, O, I, 16'h1234, I};
    vecs[2]  = '{I, O, O, O, 16'h1234, I, O, 16'h0000, O,  O, O, O, 16'h1234, I};
    vecs[3]  = '{O, O, O, O, 16'h0000, O, O, 16'h0000, O,  O, O, O, 16'h0000, O};
    for (int k = 4; k <= 9; k++) begin
      if (k % 2 == 0) vecs[k] = '{I, O, O, I, 16'h0001, I, I, 16'h0002, O,  I, O, I, 16'h0001, I};
      else            vecs[k] = '{I, O, O, I, 16'h0001, I, I, 16'h0002, O,  O, I, I, 16'h0002, O};
    end
    vecs[10] = '{O, O, O, I, 16'h0001, I, I, 16'h0002, O,  O, O, O, 16'h0000, O};
    for (int k = 11; k <= 15; k++)
      vecs[k] = '{I, I, O, I, 16'h0001, I, I, 16'h0002, O,  O, O, O, 16'h0000, O};
    vecs[16] = '{I, O, O, I, 16'h0001, I, I, 16'h0002, O,  I, O, I, 16'h0001, I};
    vecs[17] = '{I, O, O, I, 16'h0001, I, I, 16'h0002, O,  O, I, I, 16'h0002, O};
    vecs[18] = '{I, O, O, O, 16'h0001, I, I, 16'h0002, O,  O, I, I, 16'h0002, O};
    vecs[19] = '{I, O, I, I, 16'h0001, I, I, 16'h0002, O,  O, O, O, 16'h0002, O};
    vecs[20] = '{O, O, O, O, 16'h0000, O, O, 16'h0000, O,  O, O, O, 16'h0000, O};

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      rst_n = v.rst_n; freeze = v.frz; clear = v.clr;
      v0 = v.v0; a0 = v.a0; d0 = v.d0; v1 = v.v1; a1 = v.a1; d1 = v.d1;
      #1;
      chk("vec_ready0", 32'(r0_16), 32'(v.r0));
      chk("vec_ready1", 32'(r1_16), 32'(v.r1));
      @(posedge clk); #1;
      chk("vec_we", 32'(we16), 32'(v.we));
      chk("vec_addr", 32'(addr16), 32'(v.addr));
      chk("vec_dat", 32'(dat16), 32'(v.dat));
      chk("vec_busy", 32'(busy16), 32'(v.clr & v.rst_n));
      $display("vec %0d: ready=%0b%0b we=%0b addr=%h dat=%0b busy=%0b",
               i, r1_16, r0_16, we16, addr16, dat16, busy16);
    end

    rst_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = 1'b0; d1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    sweep(100, 0, 16);
    sweep(5, 3, 19);
    sweep(-1, 3, 18);

    // Reset in the middle of a sweep, then a lone writer 1 request.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (we4 && addr4 == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reached_addr7", 32'(found), 32'd1);
    v1 = 1'b1; a1 = 16'h0009; d1 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(we4), 32'd0);
    chk("rst_addr", 32'(addr4), 32'd0);
    chk("rst_dat", 32'(dat4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_ready1", 32'(r1_4), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready1", 32'(r1_4), 32'd1);
    @(posedge clk); #1;
    chk("post_rst_we", 32'(we4), 32'd1);
    chk("post_rst_addr", 32'(addr4), 32'h9);
    chk("post_rst_dat", 32'(dat4), 32'd1);
    chk("post_rst_busy", 32'(busy4), 32'd0);
    $display("reset mid-sweep: we=%0b addr=%h dat=%0b busy=%0b", we4, addr4, dat4, busy4);
    v1 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_write_sched.md
# vram_write_sched

Write-port scheduler for the 1-bit, 64 K-entry video RAM.
- Shares RAM port A between two independent pixel writers (e.g. noise generator and plotter) using round-robin arbitration.
- Adds a full-screen clear sequencer and a freeze input that halts all writes.
- Sits between the writers and the RAM's `ada`/`din`/`cea` pins, in the `LCD_CLK` domain, alongside the read-side scan logic.

## Interface
- `ADDR_W`, default 16: RAM address width; clear sweeps 2^ADDR_W entries.
- `CLEAR_VAL`, default 1'b0: data bit written during a clear sweep.

Ports:
- `i_clk` in 1: pixel clock (`LCD_CLK`); all state on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_freeze` in 1: level; while high, no grants and no writes (clear pauses in place).
- `i_clear` in 1: level; sampled high in ARB starts a clear sweep.
- `o_clear_busy` out 1: high while in CLEAR.
- `i_req0_valid` in 1, `i_req0_addr` in ADDR_W, `i_req0_dat` in 1: writer 0 request.
- `o_req0_ready` out 1: writer 0 accepted this cycle when valid & ready.
- `i_req1_valid` in 1, `i_req1_addr` in ADDR_W, `i_req1_dat` in 1: writer 1 request.
- `o_req1_ready` out 1: writer 1 accept.
- `o_we` out 1: RAM write enable (`cea`).
- `o_addr` out ADDR_W: RAM address (`ada`).
- `o_dat` out 1: RAM data (`din`).

## Operation
- FSM states:
  - ARB (reset state).
  - CLEAR.
- ARB:
  - If `i_clear`=1: both readies 0 this cycle; next state CLEAR; clear counter loaded with 0.
  - Else if `i_freeze`=0: grant one valid requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the one not granted most recently is granted.
  - Priority pointer (`last`) resets to 1, so writer 0 wins the first tie.
  - `last` updates only on an actual transfer.
- Readies:
  - Combinational from state, `i_freeze`, `i_clear`, both valids and `last`.
  - Never depend on the requester's own address or data.
- Requester rule: once valid is high, addr/dat/valid hold until ready. The bench checks this; the block does not.
- Transfer (valid & ready at edge k): `o_we`=1, `o_addr`/`o_dat` = request fields, registered after edge k.
- No transfer: `o_we`=0 after the edge; `o_addr`/`o_dat` hold last value.
- CLEAR, `i_freeze`=0, each edge:
  - `o_we`=1, `o_addr`=counter, `o_dat`=CLEAR_VAL.
  - Counter increments.
  - At counter = 2^ADDR_W−1: write issued, then next state ARB.
- CLEAR, `i_freeze`=1: `o_we`=0, counter holds, state holds.
- `i_clear` is ignored in CLEAR; a new sweep needs `i_clear` sampled in ARB.
- Readies are 0 throughout CLEAR.
- `o_clear_busy` = (state == CLEAR), registered.
- Arithmetic: counter is ADDR_W+0 bits. Terminal detect is on all-ones, not on overflow.

## Timing
- Reset values:
  - `o_we`=0, `o_addr`=0, `o_dat`=0, `o_clear_busy`=0.
  - state=ARB, counter=0, `last`=1.
  - `o_req0_ready`=`o_req1_ready`=0 while `i_rst_n`=0.
- Latency: accept at edge k → `o_we` high during cycle k..k+1 → RAM captures at edge k+1.
- Throughput: one write per cycle. With both writers continuously valid, grants alternate 0,1,0,1…
- Clear:
  - `i_clear` sampled at edge k → `o_clear_busy` high after k.
  - Writes at edges k+1 … k+2^ADDR_W with addresses 0 … 2^ADDR_W−1.
  - `o_clear_busy` low after edge k+2^ADDR_W.
  - Earliest grant is in the following cycle.
  - Each frozen cycle extends the sweep by exactly one cycle.
- Simultaneous `i_clear` and `i_freeze` in ARB: clear wins; CLEAR is entered and immediately pauses.
- Reset mid-sweep: immediate return to reset values; the sweep is not resumed.

## Structure
- Package `vram_pkg`:
  - `VRAM_ADDR_W`=16.
  - State enum {ST_ARB, ST_CLEAR}.
  - `VRAM_CLEAR_VAL`.
- Sub-module `rr_arb2`:
  - Inputs: two valids, `last`, enable.
  - Outputs: one-hot grant and next `last`.
  - Combinational grant, registered pointer.
- Top contains the FSM, clear counter and output registers.

## Test plan
- Reset, then writer 0 valid, addr 0x1234, dat 1 → `o_req0_ready`=1 in the same cycle; next cycle `o_we`=1, `o_addr`=0x1234, `o_dat`=1; then `o_we`=0.
- Both writers valid for 6 cycles (addrs 0x0001/0x0002) → grants 0,1,0,1,0,1; `o_addr` sequence 0x0001,0x0002,… one cycle later.
- `i_freeze`=1 with both valid for 5 cycles → both readies 0, `o_we`=0. Release → writer 0 granted first after reset.
- `i_clear` pulse at cycle 10, no freeze, ADDR_W=4 → 16 writes, addr 0..15, dat 0. `o_clear_busy` high for exactly 16 cycles; readies 0 throughout.
- Clear with ADDR_W=4, `i_freeze` high for 3 cycles mid-sweep → sweep lasts 19 cycles; no address skipped or repeated.
- Assert `i_rst_n`=0 at clear address 7 → outputs return to reset values at once. After release, state=ARB and writer 1 is granted on its next valid.
